// File: rtl/mux_arb_pkg.sv
// Package for the mux_arb slice: default sizing, clog2 helper and packet-lock state type.
package mux_arb_pkg;

`include "mux_arb_defs.vh"

  localparam int unsigned DEF_WIDTH = `MUX_ARB_DEF_WIDTH;
  localparam int unsigned DEF_NCH   = `MUX_ARB_DEF_NCH;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

endpackage

// File: rtl/mux_arb_defs.vh
// Shared defaults and constant helpers for the mux_arb slice; included into mux_arb_pkg.
`ifndef MUX_ARB_DEFS_VH
`define MUX_ARB_DEFS_VH

`define MUX_ARB_DEF_WIDTH 16
`define MUX_ARB_DEF_NCH   8

// Bits needed to index n items (n >= 1).
function automatic int unsigned mux_arb_clog2(input int unsigned n);
  int unsigned r;
  r = 0;
  for (int unsigned v = n - 1; v != 0; v = v >> 1) r++;
  return r;
endfunction

`endif

// File: rtl/rr_pick.sv
// Round-robin search: first set req bit strictly after ptr, wrapping modulo NCH.
module rr_pick #(
  parameter int unsigned NCH  = 8,
  parameter int unsigned SELW = 3
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      int unsigned    p;
      logic [SELW-1:0] pi;
      p = 32'(ptr) + k;
      if (p >= NCH) p = p - NCH;
      pi = SELW'(p);
      if (!found && req[pi]) begin
        found   = 1'b1;
        gnt[pi] = 1'b1;
        idx     = pi;
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// Round-robin N:1 stream mux with single-entry output register.
// Define MUX_ARB_PKT_EN to add in_last/out_last and hold the grant for whole packets.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH,
  localparam int unsigned SELW = mux_arb_clog2(NCH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
`ifdef MUX_ARB_PKT_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0]   req, gnt;
  logic [SELW-1:0]  idx;
  logic [WIDTH-1:0] sel_data;
  logic             load_en, grant;

`ifdef MUX_ARB_PKT_EN
  lock_state_t     lock_q, lock_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;
  logic            out_last_q, out_last_d;
`endif

  // While a packet is open only its channel may compete.
  always_comb begin
    req = in_valid;
`ifdef MUX_ARB_PKT_EN
    if (lock_q == LOCK_HELD) req = in_valid & (NCH'(1) << lock_ch_q);
`endif
  end

  rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx)
  );

  assign load_en  = !out_valid_q || out_ready;
  assign grant    = !reset && load_en && (|req);
  assign in_ready = grant ? gnt : '0;

  always_comb begin
    sel_data = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      sel_data = sel_data | (in_data[c*WIDTH +: WIDTH] & {WIDTH{gnt[c]}});
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
`ifdef MUX_ARB_PKT_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (grant) begin
      out_data_d  = sel_data;
      out_chan_d  = idx;
      out_valid_d = 1'b1;
      ptr_d       = idx;
`ifdef MUX_ARB_PKT_EN
      out_last_d  = in_last[idx];
      lock_d      = in_last[idx] ? LOCK_IDLE : LOCK_HELD;
      lock_ch_d   = idx;
`endif
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(NCH - 1);
`ifdef MUX_ARB_PKT_EN
      lock_q      <= LOCK_IDLE;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
`ifdef MUX_ARB_PKT_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
`ifdef MUX_ARB_PKT_EN
  assign out_last  = out_last_q;
`endif

endmodule
